controlador_necessidades: RTL and testbench

Generates the pet's three need levels (`fome`, `felicidade`, `sono`) that feed `controlador_estados`, and consumes its `estado` output to decide which need is replenished.
- Needs decay on a slow prescaled tick.
- The need matching the current activity refills.
- Values reload at INTRO and freeze at MORTO.
- Sits directly upstream of the state controller and alongside the display logic, which also reads the levels.

---
 rtl/tamagotchi_pkg.sv | 29 ++
 rtl/contador_decaimento.sv | 48 ++++
 rtl/controlador_necessidades.sv | 82 ++++++++
 tb/tb_controlador_necessidades.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/tamagotchi_pkg.sv
// Shared definitions for the pet controllers: one-hot estado codes, need width
// and the saturating level arithmetic used by every need.
package tamagotchi_pkg;

    localparam int NEED_W = 8;

    localparam logic [4:0] INTRO      = 5'd0;
    localparam logic [4:0] IDLE       = 5'd1;
    localparam logic [4:0] DORMINDO   = 5'd2;
    localparam logic [4:0] COMENDO    = 5'd4;
    localparam logic [4:0] DANDO_AULA = 5'd8;
    localparam logic [4:0] MORTO      = 5'd16;

    typedef logic [NEED_W-1:0] nivel_t;

    // Arithmetic is one bit wider so the carry/borrow selects the clamp value.
    function automatic nivel_t sat_add(input nivel_t a, input nivel_t b);
        logic [NEED_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[NEED_W] ? {NEED_W{1'b1}} : s[NEED_W-1:0];
    endfunction

    function automatic nivel_t sat_sub(input nivel_t a, input logic [1:0] step);
        logic [NEED_W:0] d;
        d = {1'b0, a} - {{(NEED_W-1){1'b0}}, step};
        return d[NEED_W] ? {NEED_W{1'b0}} : d[NEED_W-1:0];
    endfunction

endpackage

// File: rtl/contador_decaimento.sv
// One need level: tick-driven decay counter plus saturating feed/decay of the
// level register, with reload (INTRO) and freeze (MORTO) controls.
module contador_decaimento
    import tamagotchi_pkg::*;
#(
    parameter int unsigned DECAI         = 4,
    parameter nivel_t      VALOR_INICIAL = 8'd200,
    parameter nivel_t      GANHO         = 8'd8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick,
    input  logic        feed,
    input  logic [1:0]  step,
    input  logic        freeze,
    input  logic        reload,
    output nivel_t      nivel
);

    localparam logic [3:0] DECAI_M1 = 4'(DECAI - 1);

    nivel_t     nivel_reg;
    logic [3:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            nivel_reg <= VALOR_INICIAL;
            cnt_reg   <= '0;
        end else if (reload) begin
            nivel_reg <= VALOR_INICIAL;
            cnt_reg   <= '0;
        end else if (tick && !freeze) begin
            // Feeding overrides any decrement that would fall due on this tick.
            if (feed) begin
                nivel_reg <= sat_add(nivel_reg, GANHO);
                cnt_reg   <= '0;
            end else if (cnt_reg == DECAI_M1) begin
                nivel_reg <= sat_sub(nivel_reg, step);
                cnt_reg   <= '0;
            end else begin
                cnt_reg <= cnt_reg + 4'd1;
            end
        end
    end

    assign nivel = nivel_reg;

endmodule

// File: rtl/controlador_necessidades.sv
// Need-level generator for the pet: slow prescaled tick, estado decode, and
// three decay/feed channels (fome, felicidade, sono).
module controlador_necessidades
    import tamagotchi_pkg::*;
#(
    parameter int unsigned TICK_W        = 22,
    parameter nivel_t      VALOR_INICIAL = 8'd200,
    parameter nivel_t      GANHO         = 8'd8,
    parameter int unsigned DECAI_FOME    = 4,
    parameter int unsigned DECAI_SONO    = 6,
    parameter int unsigned DECAI_FELIC   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        estado,
    output logic [NEED_W-1:0] fome,
    output logic [NEED_W-1:0] felicidade,
    output logic [NEED_W-1:0] sono,
    output logic              tick
);

    // Channel order: 0 = fome, 1 = felicidade, 2 = sono.
    localparam int unsigned DECAI_TAB [3] = '{DECAI_FOME, DECAI_FELIC, DECAI_SONO};

    logic [TICK_W-1:0] pres_reg;
    logic              tick_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pres_reg <= '0;
            tick_reg <= 1'b0;
        end else begin
            pres_reg <= pres_reg + 1'b1;
            tick_reg <= &pres_reg;
        end
    end

    assign tick = tick_reg;

    logic       reload;
    logic       freeze;
    logic [2:0] feed;
    logic [1:0] step_arr [3];

    // Codes other than the listed one-hot values fall through to IDLE behaviour.
    always_comb begin
        reload      = (estado == INTRO);
        freeze      = (estado == MORTO);
        feed[0]     = (estado == COMENDO);
        feed[1]     = (estado == DANDO_AULA);
        feed[2]     = (estado == DORMINDO);
        step_arr[0] = 2'd1;
        step_arr[1] = 2'd1;
        step_arr[2] = (estado == DANDO_AULA) ? 2'd2 : 2'd1;
    end

    nivel_t niveis [3];

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_need
            contador_decaimento #(
                .DECAI         (DECAI_TAB[gi]),
                .VALOR_INICIAL (VALOR_INICIAL),
                .GANHO         (GANHO)
            ) u_need (
                .clk    (clk),
                .rst_n  (rst_n),
                .tick   (tick_reg),
                .feed   (feed[gi]),
                .step   (step_arr[gi]),
                .freeze (freeze),
                .reload (reload),
                .nivel  (niveis[gi])
            );
        end
    endgenerate

    assign fome       = niveis[0];
    assign felicidade = niveis[1];
    assign sono       = niveis[2];

endmodule

// File: tb/tb_controlador_necessidades.sv
// Randomized bench for controlador_necessidades: a level model predicts each
// tick update into a scoreboard that a monitor drains against the DUT outputs.
module tb_controlador_necessidades;

    localparam int PER   = 4;      // 2**TICK_W with TICK_W = 2
    localparam int VINIT = 200;
    localparam int GAIN  = 8;

    localparam logic [4:0] E_INTRO = 5'd0;
    localparam logic [4:0] E_IDLE  = 5'd1;
    localparam logic [4:0] E_DORM  = 5'd2;
    localparam logic [4:0] E_COME  = 5'd4;
    localparam logic [4:0] E_AULA  = 5'd8;
    localparam logic [4:0] E_MORTO = 5'd16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] estado = 5'd1;
    logic [7:0] fome, felicidade, sono;
    logic       tick;

    always #5 clk = ~clk;

    controlador_necessidades #(
        .TICK_W     (2),
        .DECAI_FOME (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .estado     (estado),
        .fome       (fome),
        .felicidade (felicidade),
        .sono       (sono),
        .tick       (tick)
    );

    typedef struct {
        int         f;
        int         h;
        int         s;
        logic [4:0] e;
    } exp_t;

    exp_t sb[$];
    exp_t mx;

    int checks = 0;
    int errors = 0;
    int ntx    = 0;

    // Model: levels as plain integers, decay as "ticks elapsed since last drop".
    int lvl     [3];
    int elapsed [3];
    int period  [3] = '{4, 5, 6};   // fome, felicidade, sono
    int pcnt;
    bit mtick;
    bit chk_init;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic void model_reload();
        for (int i = 0; i < 3; i++) begin
            lvl[i]     = VINIT;
            elapsed[i] = 0;
        end
    endfunction

    function automatic void model_tick(input logic [4:0] e);
        for (int i = 0; i < 3; i++) begin
            bit fed;
            int stp;
            fed = (i == 0 && e == E_COME) || (i == 1 && e == E_AULA) || (i == 2 && e == E_DORM);
            stp = (i == 2 && e == E_AULA) ? 2 : 1;
            if (fed) begin
                lvl[i]     = (lvl[i] + GAIN > 255) ? 255 : lvl[i] + GAIN;
                elapsed[i] = 0;
            end else begin
                elapsed[i] = elapsed[i] + 1;
                if (elapsed[i] == period[i]) begin
                    elapsed[i] = 0;
                    lvl[i]     = (lvl[i] - stp < 0) ? 0 : lvl[i] - stp;
                end
            end
        end
    endfunction

    // One clock cycle: drive on the falling edge, predict the next rising edge.
    task automatic step(input logic [4:0] e, input bit rst);
        @(negedge clk);
        if (chk_init) begin
            check("init_fome", int'(fome), VINIT);
            check("init_felicidade", int'(felicidade), VINIT);
            check("init_sono", int'(sono), VINIT);
            chk_init = 1'b0;
        end
        check("tick", int'(tick), int'(mtick));
        estado = e;
        rst_n  = !rst;
        if (rst) begin
            model_reload();
            pcnt     = 0;
            mtick    = 1'b0;
            chk_init = 1'b1;
        end else begin
            if (e == E_INTRO) begin
                model_reload();
                chk_init = 1'b1;
            end else if (mtick && e != E_MORTO) begin
                model_tick(e);
            end
            if (mtick)
                sb.push_back('{lvl[0], lvl[1], lvl[2], e});
            mtick = (pcnt == PER - 1);
            pcnt  = (pcnt + 1) % PER;
        end
    endtask

    task automatic run(input logic [4:0] e, input int n);
        for (int i = 0; i < n; i++)
            step(e, 1'b0);
    endtask

    function automatic logic [4:0] pick_estado();
        logic [4:0] tbl [6];
        int         k;
        tbl = '{E_INTRO, E_IDLE, E_DORM, E_COME, E_AULA, E_MORTO};
        k = int'($urandom_range(0, 7));
        if (k < 6)
            return tbl[k];
        return 5'($urandom);
    endfunction

    task automatic random_phase(input int nseg);
        for (int s = 0; s < nseg; s++)
            run(pick_estado(), int'($urandom_range(1, 40)));
    endtask

    // Monitor: a tick seen during a cycle means the levels after that edge are a result.
    bit pend = 1'b0;
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow: DUT tick with no expected update, got %0d/%0d/%0d",
                             fome, felicidade, sono);
                end else begin
                    mx = sb.pop_front();
                    ntx++;
                    check("fome", int'(fome), mx.f);
                    check("felicidade", int'(felicidade), mx.h);
                    check("sono", int'(sono), mx.s);
                    $display("tx %0d estado=%b fome=%0d felicidade=%0d sono=%0d",
                             ntx, mx.e, fome, felicidade, sono);
                end
            end
            pend = (tick === 1'b1);
        end
    end

    initial begin
        model_reload();
        pcnt     = 0;
        mtick    = 1'b0;
        chk_init = 1'b0;

        step(E_IDLE, 1'b1);
        step(E_IDLE, 1'b1);

        run(E_IDLE, 20 * PER);
        run(E_COME, 12 * PER);
        run(E_DORM, 12 * PER);
        run(E_AULA, 12 * PER);
        run(E_MORTO, 10 * PER);

        // Reload in a cycle with no tick, then decay sono down to 1 and let
        // DANDO_AULA's double step hit the floor.
        while (mtick)
            step(E_IDLE, 1'b0);
        step(E_INTRO, 1'b0);
        run(E_IDLE, 1194 * PER);
        run(E_AULA, 12 * PER);
        run(E_MORTO, 10 * PER);

        random_phase(150);

        // Reset asserted in a tick cycle must suppress that update.
        while (!mtick)
            step(E_COME, 1'b0);
        step(E_COME, 1'b1);
        step(E_IDLE, 1'b1);

        random_phase(150);
        run(E_IDLE, 3 * PER);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d updates never presented, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
